// File: rtl/video_sig_recv.sv
`timescale 1ns/1ps
// Pixel-timing receiver: rebuilds raster coordinates from raw hs/vs/ad strobes,
// checks line/frame timing against the expected raster and reports lock/errors.
module video_sig_recv #(
  parameter int H_ACTIVE    = 1280,
  parameter int H_TOTAL     = 1650,
  parameter int HS_START    = 1390,
  parameter int V_ACTIVE    = 720,
  parameter int V_TOTAL     = 750,
  parameter int VS_START    = 725,
  parameter int LOCK_FRAMES = 2,
  parameter int FC_WRAP     = 60
) (
  input  logic        clk_pixel_in,
  input  logic        rst_n_in,
  input  logic        hs_in,
  input  logic        vs_in,
  input  logic        ad_in,
  output logic [10:0] hcount_out,
  output logic [9:0]  vcount_out,
  output logic        ad_out,
  output logic        nf_out,
  output logic [5:0]  fc_out,
  output logic        locked_out,
  output logic        err_out,
  output logic [7:0]  err_count_out
);

  localparam logic [10:0] H_ACT_W = 11'(H_ACTIVE);
  localparam logic [10:0] H_TOT_W = 11'(H_TOTAL);
  localparam logic [10:0] H_LAST  = 11'(H_TOTAL - 1);
  localparam logic [10:0] HS_LOAD = 11'(HS_START);
  localparam logic [9:0]  V_ACT_W = 10'(V_ACTIVE);
  localparam logic [9:0]  V_LAST  = 10'(V_TOTAL - 1);
  localparam logic [9:0]  VS_LOAD = 10'(VS_START);
  localparam logic [10:0] V_TOT_W = 11'(V_TOTAL);
  localparam logic [5:0]  FC_LAST = 6'(FC_WRAP - 1);
  localparam logic [3:0]  LOCK_N  = 4'(LOCK_FRAMES);

  typedef enum logic [1:0] {IDLE, ACQUIRE, LOCKED} state_t;

  state_t      state, state_nx;
  logic [3:0]  good, good_nx;
  logic        hs_d, vs_d;
  logic        hs_rise, vs_rise, h_wrap;
  logic [10:0] clk_cnt, ad_cnt, line_cnt, ad_exp;
  logic        hs_arm, err_flag;
  logic        checking, line_err, frame_err, err_now;

  assign hs_rise = hs_in & ~hs_d;
  assign vs_rise = vs_in & ~vs_d;
  assign h_wrap  = ~hs_rise & (hcount_out == H_LAST);

  // The line closed by this hs_rise carries the current recovered vcount.
  assign ad_exp    = (vcount_out < V_ACT_W) ? H_ACT_W : '0;
  assign checking  = (state != IDLE);
  assign line_err  = checking & hs_rise & hs_arm &
                     ((clk_cnt != H_TOT_W) | (ad_cnt != ad_exp));
  assign frame_err = checking & vs_rise & (line_cnt != V_TOT_W);
  assign err_now   = line_err | frame_err;

  always_comb begin
    state_nx = state;
    good_nx  = good;
    case (state)
      IDLE: begin
        if (vs_rise) begin
          state_nx = ACQUIRE;
          good_nx  = '0;
        end
      end
      ACQUIRE: begin
        if (err_now) begin
          good_nx = '0;
        end else if (vs_rise && !err_flag) begin
          if (good + 4'd1 >= LOCK_N) begin
            state_nx = LOCKED;
            good_nx  = '0;
          end else begin
            good_nx = good + 4'd1;
          end
        end
      end
      LOCKED: begin
        if (err_now) begin
          state_nx = ACQUIRE;
          good_nx  = '0;
        end
      end
      default: begin
        state_nx = IDLE;
        good_nx  = '0;
      end
    endcase
  end

  always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state      <= IDLE;
      good       <= '0;
      locked_out <= 1'b0;
    end else begin
      state      <= state_nx;
      good       <= good_nx;
      locked_out <= (state_nx == LOCKED);
    end
  end

  always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      hs_d       <= 1'b0;
      vs_d       <= 1'b0;
      hcount_out <= '0;
      vcount_out <= '0;
      ad_out     <= 1'b0;
      nf_out     <= 1'b0;
      fc_out     <= '0;
    end else begin
      hs_d   <= hs_in;
      vs_d   <= vs_in;
      ad_out <= ad_in;
      nf_out <= vs_rise;
      if (hs_rise)
        hcount_out <= HS_LOAD;
      else if (h_wrap)
        hcount_out <= '0;
      else
        hcount_out <= hcount_out + 11'd1;
      // vs reload wins over a line wrap landing on the same clock
      if (vs_rise)
        vcount_out <= VS_LOAD;
      else if (h_wrap)
        vcount_out <= (vcount_out == V_LAST) ? '0 : vcount_out + 10'd1;
      if (vs_rise)
        fc_out <= (fc_out == FC_LAST) ? '0 : fc_out + 6'd1;
    end
  end

  always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      clk_cnt       <= '0;
      ad_cnt        <= '0;
      line_cnt      <= '0;
      hs_arm        <= 1'b0;
      err_flag      <= 1'b0;
      err_out       <= 1'b0;
      err_count_out <= '0;
    end else begin
      if (hs_rise) begin
        clk_cnt <= 11'd1;
        ad_cnt  <= {10'd0, ad_in};
      end else begin
        if (clk_cnt != '1)
          clk_cnt <= clk_cnt + 11'd1;
        if (ad_cnt != '1)
          ad_cnt <= ad_cnt + {10'd0, ad_in};
      end
      if (vs_rise)
        line_cnt <= {10'd0, hs_rise};
      else if (hs_rise && line_cnt != '1)
        line_cnt <= line_cnt + 11'd1;
      if (hs_rise && checking)
        hs_arm <= 1'b1;
      if (vs_rise)
        err_flag <= 1'b0;
      else if (err_now)
        err_flag <= 1'b1;
      err_out <= err_now;
      if (err_now && err_count_out != '1)
        err_count_out <= err_count_out + 8'd1;
    end
  end

endmodule

// File: tb/tb_video_sig_recv.sv
`timescale 1ns/1ps
// Bench for video_sig_recv on a reduced raster: a generator drives hs/vs/ad,
// a scoreboard tracks coordinates/fc, and scenario tasks check error/lock behaviour.
module tb_video_sig_recv;

  localparam int HA = 16;
  localparam int HT = 24;
  localparam int HS = 18;
  localparam int VA = 8;
  localparam int VT = 12;
  localparam int VS = 9;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        hs = 1'b0, vs = 1'b0, ad = 1'b0;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        ad_o, nf, lk, err;
  logic [5:0]  fc;
  logic [7:0]  errc;

  video_sig_recv #(
    .H_ACTIVE(HA), .H_TOTAL(HT), .HS_START(HS),
    .V_ACTIVE(VA), .V_TOTAL(VT), .VS_START(VS),
    .LOCK_FRAMES(2), .FC_WRAP(60)
  ) dut (
    .clk_pixel_in(clk), .rst_n_in(rst_n),
    .hs_in(hs), .vs_in(vs), .ad_in(ad),
    .hcount_out(hcount), .vcount_out(vcount), .ad_out(ad_o),
    .nf_out(nf), .fc_out(fc), .locked_out(lk),
    .err_out(err), .err_count_out(errc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [10:0] h;
    logic [9:0]  v;
    logic        a;
  } hv_t;

  hv_t         hv_q[$];
  logic [5:0]  fc_q[$];
  int          n_cmp = 0;
  int          n_bad = 0;
  int unsigned cyc = 0, vs_cyc = 0, err_cyc = 0, lock_cyc = 0, err_seen = 0;
  int unsigned hs_cyc [0:VT-1];
  logic        err_lk = 1'b0;
  logic [9:0]  err_v = '0;
  logic        nf_prev = 1'b0, lk_prev = 1'b0, vs_prev = 1'b0;
  int          fc_model = 0;

  // One pixel clock: drive inputs, push expectations, sample #1 after the edge.
  task automatic step(input logic h_i, input logic v_i, input logic a_i,
                      input bit sb, input int gh, input int gv);
    hv_t e;
    hs = h_i; vs = v_i; ad = a_i;
    cyc++;
    if (sb) hv_q.push_back('{h: 11'(gh), v: 10'(gv), a: a_i});
    if (v_i && !vs_prev) begin
      fc_model = (fc_model == 59) ? 0 : fc_model + 1;
      fc_q.push_back(6'(fc_model));
      vs_cyc = cyc;
    end
    vs_prev = v_i;
    @(posedge clk);
    #1;
    if (hv_q.size() > 0) begin
      e = hv_q.pop_front();
      n_cmp++;
      if (hcount !== e.h || vcount !== e.v || ad_o !== e.a) begin
        n_bad++;
        $display("FAIL hv_track cyc=%0d got h=%0d v=%0d ad=%b expected h=%0d v=%0d ad=%b",
                 cyc, hcount, vcount, ad_o, e.h, e.v, e.a);
      end
    end
    if (nf === 1'b1) begin
      n_cmp++;
      if (nf_prev !== 1'b0) begin
        n_bad++;
        $display("FAIL nf_width cyc=%0d nf high on consecutive cycles, expected 1-cycle pulse", cyc);
      end
      n_cmp++;
      if (fc_q.size() == 0) begin
        n_bad++;
        $display("FAIL nf_unexpected cyc=%0d got nf=1 expected no pulse", cyc);
      end else begin
        e.h = '0;
        if (fc !== fc_q[0]) begin
          n_bad++;
          $display("FAIL fc_track cyc=%0d got fc=%0d expected %0d", cyc, fc, fc_q[0]);
        end
        void'(fc_q.pop_front());
      end
    end
    if (err === 1'b1) begin
      err_seen++;
      err_cyc = cyc;
      err_lk  = lk;
      err_v   = vcount;
    end
    if (lk === 1'b1 && lk_prev === 1'b0) lock_cyc = cyc;
    nf_prev = nf;
    lk_prev = lk;
  endtask

  // Generator: one frame with optional skipped line, stretched line(s) (-2 = all),
  // one-pixel ad dropout, and early stop after max_cycles (-1 = full frame).
  task automatic run_frame(input int skip_line, input int stretch_line,
                           input int gap_line, input bit sb, input int max_cycles);
    int n;
    n = 0;
    for (int v = 0; v < VT; v++) begin
      int len;
      len = (stretch_line == v || stretch_line == -2) ? HT + 1 : HT;
      if (v != skip_line) begin
        for (int h = 0; h < len; h++) begin
          if (max_cycles >= 0 && n >= max_cycles) return;
          step(h >= HS && h < HS + 2, v >= VS && v < VS + 2,
               h < HA && v < VA && !(v == gap_line && h == 5), sb, h, v);
          if (h == HS) hs_cyc[v] = cyc;
          n++;
        end
      end
    end
  endtask

  task automatic clean_frames(input int count, input bit sb);
    for (int i = 0; i < count; i++) run_frame(-1, -1, -1, sb, -1);
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    n_cmp++;
    if ({hcount, vcount, ad_o, nf, fc, lk, err, errc} !== '0) begin
      n_bad++;
      $display("FAIL reset_values got h=%0d v=%0d ad=%b nf=%b fc=%0d lk=%b err=%b errc=%0d expected all 0",
               hcount, vcount, ad_o, nf, fc, lk, err, errc);
    end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_lock;
    clean_frames(1, 1'b0);
    clean_frames(1, 1'b1);
    n_cmp++;
    if (lk !== 1'b0) begin
      n_bad++;
      $display("FAIL lock_early got locked=%b after 2 vs_rise expected 0", lk);
    end
    clean_frames(1, 1'b1);
    n_cmp++;
    if (lk !== 1'b1 || lock_cyc != vs_cyc) begin
      n_bad++;
      $display("FAIL lock_third_vs got locked=%b at cyc %0d expected 1 at cyc %0d", lk, lock_cyc, vs_cyc);
    end
    clean_frames(1, 1'b1);
    n_cmp++;
    if (errc !== 8'd0 || err_seen != 0) begin
      n_bad++;
      $display("FAIL clean_errors got err_count=%0d pulses=%0d expected 0", errc, err_seen);
    end
  endtask

  task automatic test_ad_gap;
    int unsigned e0;
    e0 = err_seen;
    run_frame(-1, -1, 4, 1'b1, -1);
    n_cmp++;
    if (err_seen - e0 != 1 || err_cyc != hs_cyc[4] || err_lk !== 1'b0) begin
      n_bad++;
      $display("FAIL ad_gap_err got pulses=%0d at cyc %0d locked=%b expected 1 at cyc %0d locked=0",
               err_seen - e0, err_cyc, err_lk, hs_cyc[4]);
    end
    n_cmp++;
    if (errc !== 8'd1) begin
      n_bad++;
      $display("FAIL ad_gap_count got err_count=%0d expected 1", errc);
    end
    clean_frames(1, 1'b1);
    n_cmp++;
    if (lk !== 1'b0) begin
      n_bad++;
      $display("FAIL ad_gap_relock_early got locked=%b expected 0", lk);
    end
    clean_frames(1, 1'b1);
    n_cmp++;
    if (lk !== 1'b1) begin
      n_bad++;
      $display("FAIL ad_gap_relock got locked=%b expected 1", lk);
    end
  endtask

  task automatic test_stretch;
    int unsigned e0;
    e0 = err_seen;
    run_frame(-1, 3, -1, 1'b0, -1);
    n_cmp++;
    if (err_seen - e0 != 1 || err_cyc != hs_cyc[4] || err_lk !== 1'b0) begin
      n_bad++;
      $display("FAIL stretch_err got pulses=%0d at cyc %0d locked=%b expected 1 at cyc %0d locked=0",
               err_seen - e0, err_cyc, err_lk, hs_cyc[4]);
    end
    n_cmp++;
    if (errc !== 8'd2) begin
      n_bad++;
      $display("FAIL stretch_count got err_count=%0d expected 2", errc);
    end
    clean_frames(1, 1'b1);
    n_cmp++;
    if (lk !== 1'b0) begin
      n_bad++;
      $display("FAIL stretch_relock_early got locked=%b expected 0", lk);
    end
    clean_frames(1, 1'b1);
    n_cmp++;
    if (lk !== 1'b1 || lock_cyc != vs_cyc) begin
      n_bad++;
      $display("FAIL stretch_relock got locked=%b at cyc %0d expected 1 at cyc %0d", lk, lock_cyc, vs_cyc);
    end
  endtask

  task automatic test_short_frame;
    int unsigned e0;
    e0 = err_seen;
    run_frame(VS - 1, -1, -1, 1'b1, -1);
    n_cmp++;
    if (err_seen - e0 != 1 || err_cyc != vs_cyc || err_v !== 10'(VS)) begin
      n_bad++;
      $display("FAIL short_frame_err got pulses=%0d at cyc %0d vcount=%0d expected 1 at cyc %0d vcount=%0d",
               err_seen - e0, err_cyc, err_v, vs_cyc, VS);
    end
    n_cmp++;
    if (errc !== 8'd3) begin
      n_bad++;
      $display("FAIL short_frame_count got err_count=%0d expected 3", errc);
    end
  endtask

  task automatic test_reset_midline;
    run_frame(-1, -1, -1, 1'b1, 5 * HT + 7);
    #2;
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({hcount, vcount, ad_o, nf, fc, lk, err, errc} !== '0) begin
      n_bad++;
      $display("FAIL async_reset got h=%0d v=%0d fc=%0d lk=%b errc=%0d expected all 0",
               hcount, vcount, fc, lk, errc);
    end
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    hv_q.delete();
    fc_q.delete();
    fc_model = 0;
    vs_prev  = 1'b0;
    nf_prev  = 1'b0;
    lk_prev  = 1'b0;
    lock_cyc = 0;
  endtask

  task automatic test_fc_wrap;
    clean_frames(1, 1'b0);
    clean_frames(1, 1'b1);
    n_cmp++;
    if (lk !== 1'b0) begin
      n_bad++;
      $display("FAIL relock_after_reset_early got locked=%b expected 0", lk);
    end
    clean_frames(1, 1'b1);
    n_cmp++;
    if (lk !== 1'b1 || lock_cyc != vs_cyc) begin
      n_bad++;
      $display("FAIL relock_after_reset got locked=%b at cyc %0d expected 1 at cyc %0d", lk, lock_cyc, vs_cyc);
    end
    clean_frames(58, 1'b1);
    n_cmp++;
    if (fc !== 6'd1 || fc_q.size() != 0) begin
      n_bad++;
      $display("FAIL fc_wrap got fc=%0d pending=%0d expected fc=1 pending=0", fc, fc_q.size());
    end
    n_cmp++;
    if (errc !== 8'd0) begin
      n_bad++;
      $display("FAIL errc_after_reset got %0d expected 0", errc);
    end
  endtask

  task automatic test_err_saturate;
    int unsigned e0;
    e0 = err_seen;
    for (int i = 0; i < 26; i++) run_frame(-1, -2, -1, 1'b0, -1);
    n_cmp++;
    if (err_seen - e0 < 300) begin
      n_bad++;
      $display("FAIL err_inject got %0d pulses expected at least 300", err_seen - e0);
    end
    n_cmp++;
    if (errc !== 8'd255) begin
      n_bad++;
      $display("FAIL err_saturate got err_count=%0d expected 255", errc);
    end
  endtask

  initial begin
    test_reset();
    test_lock();
    test_ad_gap();
    test_stretch();
    test_short_frame();
    test_reset_midline();
    test_fc_wrap();
    test_err_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
